// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer:
// FSM state encodings, the default operand width and an index-width helper.
package byte_serial_add_ctrl_pkg;

  // Sequencer states; encodings kept stable for legacy tooling that decodes them
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default operand width in bytes
  localparam int DEFAULT_NBYTES = 4;

  // Byte index width: enough to count NBYTES positions, never narrower than 1 bit
  function automatic int idxWidth(input int nBytes);
    return (nBytes > 1) ? $clog2(nBytes) : 1;
  endfunction

endpackage

// File: rtl/byte_serial_add_ctrl_hybrid_adder.sv
// 8-bit adder slice shared by every byte of the serial operation.
// Low nibble ripples; high nibble is precomputed for both carry-in values and
// the low-nibble carry picks one, shortening the carry path through the slice.
module hybrid_adder (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cyIn,
  output logic [7:0] o_sum,
  output logic       o_cyOut
);

  logic [4:0] w_lo;
  logic [4:0] w_hi0;
  logic [4:0] w_hi1;

  // Low nibble plus both speculative high-nibble sums
  always_comb begin
    w_lo  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0000, i_cyIn};
    w_hi0 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
    w_hi1 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + 5'd1;
  end

  // Carry out of the low nibble selects the matching high-nibble result
  always_comb begin
    o_sum[3:0] = w_lo[3:0];
    if (w_lo[4]) begin
      o_sum[7:4] = w_hi1[3:0];
      o_cyOut    = w_hi1[4];
    end else begin
      o_sum[7:4] = w_hi0[3:0];
      o_cyOut    = w_hi0[4];
    end
  end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial add/subtract sequencer. One 8-bit adder slice is reused for each
// byte of an NBYTES-wide operation, LSB first, with the carry held in a
// register between bytes. Subtraction is A + ~B + 1 (carry seeded with 1).
import byte_serial_add_ctrl_pkg::*;

module byte_serial_add_ctrl #(
  parameter int NBYTES = DEFAULT_NBYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                carry,
  output logic                overflow,
  output logic                zero
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = idxWidth(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  logic [1:0]      r_state;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cy;
  logic [W-1:0]    r_result;
  logic            r_carry;
  logic            r_overflow;
  logic            r_zero;
  logic            r_done;

  logic            w_accept;
  logic            w_last;
  logic [IDXW+2:0] w_bitBase;
  logic [7:0]      w_aByte;
  logic [7:0]      w_bByte;
  logic [7:0]      w_sum;
  logic            w_cyOut;
  logic [W-1:0]    w_nextResult;

  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last    = (r_idx == LAST_IDX);
  assign w_bitBase = {r_idx, 3'b000};
  assign w_aByte   = r_a[w_bitBase +: 8];
  assign w_bByte   = r_b[w_bitBase +: 8];

  hybrid_adder u_adder (
    .i_a     (w_aByte),
    .i_b     (w_bByte),
    .i_cyIn  (r_cy),
    .o_sum   (w_sum),
    .o_cyOut (w_cyOut)
  );

  // Result as it will look after the current byte is written back
  always_comb begin
    w_nextResult = r_result;
    w_nextResult[w_bitBase +: 8] = w_sum;
  end

  // Sequencer FSM plus operand, carry, result and flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_cy       <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_cy    <= sub;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
          end else begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_result <= w_nextResult;
          r_cy     <= w_cyOut;
          r_idx    <= r_idx + 1'b1;
          if (w_last) begin
            r_carry    <= w_cyOut;
            r_overflow <= (r_a[W-1] == r_b[W-1]) && (w_sum[7] != r_a[W-1]);
            r_zero     <= (w_nextResult == '0);
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule
